// File: rtl/collision_event_scheduler.sv
// Collision event scheduler: latches per-source collision pulses during a frame,
// snapshots them at startOfFrame and dispatches them one at a time in priority order.
// Latency: first evValid 2 cycles after the startOfFrame edge; events spaced >= 2 cycles apart.
// Backpressure: evValid/evReady handshake; an event stalled TIMEOUT_CYCLES cycles is dropped.
//
// Ports:
//   clk, resetN (sync, active-low)     - clock and reset
//   startOfFrame                       - frame strobe; snapshots pending into the batch
//   collisionBall*                     - one-cycle collision pulses, sources 1 (Bottom) .. 7 (Frame)
//   evReady / evValid / evCode         - event handshake; evCode is 0 whenever evValid is 0
//   busy                               - a batch is being dispatched
//   overrun / timeoutDrop              - one-cycle pulses on discarded / timed-out events
//   eventCount, dropCount              - only when COLLISION_EVENT_STATS_EN is defined:
//                                        saturating accepted-event and dropped-event counts
module collision_event_scheduler #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       collisionBallBottom,
    input  logic       collisionBallSpringPulse,
    input  logic       collisionBallBumper,
    input  logic       collisionBallObstacleBad,
    input  logic       collisionBallObstacleGood,
    input  logic       collisionBallFlipper,
    input  logic       collisionBallFrame,
    input  logic       evReady,
    output logic       evValid,
    output logic [2:0] evCode,
    output logic       busy,
    output logic       overrun,
    output logic       timeoutDrop
`ifdef COLLISION_EVENT_STATS_EN
    ,
    output logic [7:0] eventCount,
    output logic [7:0] dropCount
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t          state_q;
    logic [6:0]      pending_q;
    logic [6:0]      batch_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            ev_valid_q;
    logic [2:0]      ev_code_q;
    logic            busy_q;
    logic            overrun_q;
    logic            timeout_drop_q;

    // Bit i of the source vector corresponds to source number i+1.
    logic [6:0] coll_w;
    assign coll_w = {collisionBallFrame, collisionBallFlipper, collisionBallObstacleGood,
                     collisionBallObstacleBad, collisionBallBumper, collisionBallSpringPulse,
                     collisionBallBottom};

    // Lowest-numbered set bit wins; returns the 1-based source number.
    function automatic logic [2:0] prio_code(input logic [6:0] bits);
        logic [2:0] code;
        code = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (bits[i]) code = 3'(i + 1);
        end
        return code;
    endfunction

    logic       accept_w;
    logic       to_hit_w;
    logic [6:0] cur_mask_w;
    logic [6:0] batch_after_w;

    // batch_after_w is the batch once this cycle's handshake or timeout is applied; it is
    // what survives into the next cycle, and at a snapshot it is what gets discarded.
    always_comb begin
        accept_w      = (state_q == S_PRESENT) && evReady;
        to_hit_w      = (state_q == S_PRESENT) && !evReady
                        && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
        cur_mask_w    = (ev_code_q != 3'd0) ? (7'd1 << (ev_code_q - 3'd1)) : 7'd0;
        batch_after_w = batch_q;
        if (accept_w) begin
            // Accepting a Bottom event ends the frame's play: lower-priority events are
            // silently discarded (neither delivered nor counted as drops).
            batch_after_w = (ev_code_q == 3'd1) ? 7'd0 : (batch_q & ~cur_mask_w);
        end else if (to_hit_w) begin
            batch_after_w = batch_q & ~cur_mask_w;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q        <= S_IDLE;
            pending_q      <= 7'd0;
            batch_q        <= 7'd0;
            to_cnt_q       <= '0;
            ev_valid_q     <= 1'b0;
            ev_code_q      <= 3'd0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_drop_q <= 1'b0;
        end else begin
            // A pulse coincident with startOfFrame belongs to the new frame.
            pending_q      <= startOfFrame ? coll_w : (pending_q | coll_w);
            batch_q        <= batch_after_w;
            overrun_q      <= 1'b0;
            timeout_drop_q <= to_hit_w;

            if (startOfFrame) begin
                batch_q    <= pending_q;
                overrun_q  <= |batch_after_w;
                ev_valid_q <= 1'b0;
                ev_code_q  <= 3'd0;
                if (|pending_q) begin
                    state_q <= S_LOAD;
                    busy_q  <= 1'b1;
                end else begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            end else begin
                case (state_q)
                    S_LOAD: begin
                        ev_code_q  <= prio_code(batch_q);
                        to_cnt_q   <= '0;
                        ev_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_PRESENT;
                    end
                    S_PRESENT: begin
                        if (accept_w || to_hit_w) begin
                            ev_valid_q <= 1'b0;
                            ev_code_q  <= 3'd0;
                            if (|batch_after_w) begin
                                state_q <= S_LOAD;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q    <= S_IDLE;
                        ev_valid_q <= 1'b0;
                        ev_code_q  <= 3'd0;
                        busy_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign evValid     = ev_valid_q;
    assign evCode      = ev_code_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign timeoutDrop = timeout_drop_q;

`ifdef COLLISION_EVENT_STATS_EN
    logic [7:0] event_cnt_q;
    logic [7:0] drop_cnt_q;
    logic [8:0] drop_sum_w;
    logic [3:0] drop_inc_w;

    // One cycle can carry a timeout plus an overrun of the remaining bits.
    always_comb begin
        drop_inc_w = {3'd0, to_hit_w};
        if (startOfFrame) drop_inc_w = drop_inc_w + 4'($countones(batch_after_w));
        drop_sum_w = {1'b0, drop_cnt_q} + {5'd0, drop_inc_w};
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            event_cnt_q <= 8'd0;
            drop_cnt_q  <= 8'd0;
        end else begin
            if (accept_w && (event_cnt_q != 8'hFF)) event_cnt_q <= event_cnt_q + 8'd1;
            drop_cnt_q <= drop_sum_w[8] ? 8'hFF : drop_sum_w[7:0];
        end
    end

    assign eventCount = event_cnt_q;
    assign dropCount  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_collision_event_scheduler.sv
module tb_collision_event_scheduler;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic [6:0] coll;
    logic       evReady;
    logic       evValid;
    logic [2:0] evCode;
    logic       busy;
    logic       overrun;
    logic       timeoutDrop;
`ifdef COLLISION_EVENT_STATS_EN
    logic [7:0] eventCount;
    logic [7:0] dropCount;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    collision_event_scheduler #(.TIMEOUT_CYCLES(4), .TO_W(3)) dut (
        .clk                      (clk),
        .resetN                   (resetN),
        .startOfFrame             (startOfFrame),
        .collisionBallBottom      (coll[0]),
        .collisionBallSpringPulse (coll[1]),
        .collisionBallBumper      (coll[2]),
        .collisionBallObstacleBad (coll[3]),
        .collisionBallObstacleGood(coll[4]),
        .collisionBallFlipper     (coll[5]),
        .collisionBallFrame       (coll[6]),
        .evReady                  (evReady),
        .evValid                  (evValid),
        .evCode                   (evCode),
        .busy                     (busy),
        .overrun                  (overrun),
        .timeoutDrop              (timeoutDrop)
`ifdef COLLISION_EVENT_STATS_EN
        ,
        .eventCount               (eventCount),
        .dropCount                (dropCount)
`endif
    );

    // Outputs are sampled 1 ns after the rising edge they were registered on.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the full handshake-side output set in one call.
    task automatic chk_out(input string tag, input logic v, input logic [2:0] c,
                           input logic b, input logic o, input logic t);
        chk({tag, ".evValid"},     {7'd0, evValid},     {7'd0, v});
        chk({tag, ".evCode"},      {5'd0, evCode},      {5'd0, c});
        chk({tag, ".busy"},        {7'd0, busy},        {7'd0, b});
        chk({tag, ".overrun"},     {7'd0, overrun},     {7'd0, o});
        chk({tag, ".timeoutDrop"}, {7'd0, timeoutDrop}, {7'd0, t});
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; coll = 7'd0; evReady = 1'b0;
        tick(); tick();
        chk_out("reset", 0, 0, 0, 0, 0);
`ifdef COLLISION_EVENT_STATS_EN
        chk("reset.eventCount", eventCount, 8'd0);
        chk("reset.dropCount", dropCount, 8'd0);
`endif
        resetN = 1'b1;
        tick();

        // Frame 0: spring (2) and frame (7), consumer always ready.
        evReady = 1'b1;
        coll = 7'b0000010; tick();
        coll = 7'b1000000; tick();
        coll = 7'd0;       tick();
        startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0;
        chk_out("f0.load1", 0, 0, 1, 0, 0);
        tick(); chk_out("f0.pres2", 1, 2, 1, 0, 0);
        tick(); chk_out("f0.load2", 0, 0, 1, 0, 0);
        tick(); chk_out("f0.pres7", 1, 7, 1, 0, 0);
        tick(); chk_out("f0.idle",  0, 0, 0, 0, 0);

        // Bumper pulsed three times merges into a single event.
        coll = 7'b0000100; tick();
        coll = 7'd0;       tick();
        coll = 7'b0000100; tick(); tick();
        coll = 7'd0;       tick();
        startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0;
        tick(); chk_out("bump.pres3", 1, 3, 1, 0, 0);
        tick(); chk_out("bump.idle",  0, 0, 0, 0, 0);
        tick(); chk_out("bump.once",  0, 0, 0, 0, 0);

        // Obstacle-good coincident with startOfFrame belongs to the next frame.
        coll = 7'b0010000; startOfFrame = 1'b1; tick();
        coll = 7'd0; startOfFrame = 1'b0;
        chk_out("og.nodisp", 0, 0, 0, 0, 0);
        tick(); chk_out("og.still", 0, 0, 0, 0, 0);
        startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0;
        chk_out("og.load", 0, 0, 1, 0, 0);
        tick(); chk_out("og.pres5", 1, 5, 1, 0, 0);
        tick(); chk_out("og.idle",  0, 0, 0, 0, 0);

        // Timeout: sources 4 and 6 with the consumer stalled (TIMEOUT_CYCLES=4).
        evReady = 1'b0;
        coll = 7'b0101000; tick();
        coll = 7'd0;
        startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0;
        tick(); chk_out("to.pres4", 1, 4, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk_out($sformatf("to.wait4_%0d", i), 1, 4, 1, 0, 0);
        end
        tick(); chk_out("to.drop4", 0, 0, 1, 0, 1);
        tick(); chk_out("to.pres6", 1, 6, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk_out($sformatf("to.wait6_%0d", i), 1, 6, 1, 0, 0);
        end
        tick(); chk_out("to.drop6", 0, 0, 0, 0, 1);
        tick(); chk_out("to.after", 0, 0, 0, 0, 0);

        // Bottom accepted clears sources 3 and 7 without dispatch or pulses.
        evReady = 1'b1;
        coll = 7'b1000101; tick();
        coll = 7'd0;
        startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0;
        tick(); chk_out("bot.pres1", 1, 1, 1, 0, 0);
        tick(); chk_out("bot.idle",  0, 0, 0, 0, 0);
        tick(); chk_out("bot.quiet", 0, 0, 0, 0, 0);
        startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0;
        chk_out("bot.nooverrun", 0, 0, 0, 0, 0);

        // Overrun: sources 2,3 stalled when the next frame brings source 7.
        evReady = 1'b0;
        coll = 7'b0000110; tick();
        coll = 7'd0;
        startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0;
        tick(); chk_out("ov.pres2", 1, 2, 1, 0, 0);
        coll = 7'b1000000; tick();
        coll = 7'd0;
        startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0;
        chk_out("ov.pulse", 0, 0, 1, 1, 0);
        tick(); chk_out("ov.pres7", 1, 7, 1, 0, 0);
        evReady = 1'b1;
        tick(); chk_out("ov.idle", 0, 0, 0, 0, 0);
`ifdef COLLISION_EVENT_STATS_EN
        // Accepted: 2,7,3,5,1,7 = 6. Dropped: two timeouts + two overrun bits = 4.
        chk("stats.eventCount", eventCount, 8'd6);
        chk("stats.dropCount", dropCount, 8'd4);
`endif

        // Reset mid-dispatch abandons the batch without an overrun pulse.
        evReady = 1'b0;
        coll = 7'b0001000; tick();
        coll = 7'd0;
        startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0;
        tick(); chk_out("rst.pres4", 1, 4, 1, 0, 0);
        resetN = 1'b0; tick();
        chk_out("rst.mid", 0, 0, 0, 0, 0);
        resetN = 1'b1;
        startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0;
        chk_out("rst.empty", 0, 0, 0, 0, 0);
`ifdef COLLISION_EVENT_STATS_EN
        chk("rst.eventCount", eventCount, 8'd0);
        chk("rst.dropCount", dropCount, 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/collision_event_scheduler.md
Name: collision_event_scheduler

Overview:
- Collects one-cycle collision pulses from the collision detector during a video frame and latches each pulse as a pending event per source.
- At each startOfFrame, the pending set is snapshotted into a dispatch batch.
- The batch is presented one event at a time, in fixed priority order, to the game-logic consumer (physics/score) over a valid/ready handshake.
- Sits between the collision detector and the ball-physics/score engines so that no collision is lost or handled twice.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles an event may wait for evReady before it is dropped; minimum 2.
- TO_W, 11: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous active-low reset, sampled on rising clk.
- startOfFrame  in  1  one-cycle frame boundary strobe.
- collisionBallBottom  in  1  ball reached bottom (source 1, highest priority).
- collisionBallSpringPulse  in  1  source 2.
- collisionBallBumper  in  1  source 3.
- collisionBallObstacleBad  in  1  source 4.
- collisionBallObstacleGood  in  1  source 5.
- collisionBallFlipper  in  1  source 6.
- collisionBallFrame  in  1  source 7 (lowest priority).
- evReady  in  1  consumer accepts the current event.
- evValid  out  1  event presented.
- evCode  out  3  source number 1..7; 0 when evValid=0.
- busy  out  1  batch dispatch in progress.
- overrun  out  1  one-cycle pulse: undispatched events were discarded at startOfFrame.
- timeoutDrop  out  1  one-cycle pulse: current event dropped by timeout.

Behaviour:
- Reset (resetN=0 at clk edge) forces the following: pending=0, batch=0, state IDLE, timeout counter=0, evValid=0, evCode=0, busy=0, overrun=0, timeoutDrop=0. Reset mid-dispatch abandons the batch with no overrun pulse.
- Pending register, 7 bits: bit i is set on any cycle where source i pulses. It holds until snapshot. Repeated pulses of the same source within a frame merge into one event.
- Snapshot occurs on the cycle startOfFrame=1:
  - batch <= pending; pending <= collision inputs of this same cycle. A pulse coincident with startOfFrame belongs to the new frame.
  - If batch is nonzero at snapshot (previous batch unfinished), overrun pulses for 1 cycle and the old batch is discarded.
- States:
  - IDLE: evValid=0, busy=0. On snapshot with nonzero pending, go to LOAD next cycle. With zero pending, stay in IDLE.
  - LOAD: one cycle, busy=1. Select the lowest-numbered set batch bit, register it into evCode, clear the timeout counter, then go to PRESENT.
  - PRESENT: evValid=1, busy=1, evCode stable.
    - If evReady=1, the handshake completes this cycle and the batch bit is cleared.
    - If evReady=0 and the counter reaches TIMEOUT_CYCLES-1, the bit is cleared and timeoutDrop pulses.
    - After either, go to LOAD if batch bits remain, else IDLE.
    - Otherwise the counter increments.
- Latency:
  - First evValid appears 2 cycles after the startOfFrame edge.
  - Back-to-back events are spaced at 2 cycles minimum (PRESENT, LOAD).
- Snapshot during LOAD or PRESENT: if the current event's handshake completes in that same cycle, it is counted as delivered. The remaining old bits trigger overrun. State goes to LOAD if the new batch is nonzero, else IDLE.
- Bottom priority rule: when source 1 is accepted, all lower-priority batch bits are cleared without dispatch. No overrun or timeoutDrop pulse is generated.
- evCode changes only in LOAD. A dropped or accepted event is never re-presented.

Optional Feature:
- Macro COLLISION_EVENT_STATS_EN.
- When defined, add an output eventCount[7:0], a saturating count of events accepted since reset, cleared by reset only.
- When defined, add an output dropCount[7:0], a saturating count of timeouts plus overrun-discarded events, cleared by reset only. An overrun adds the popcount of the discarded bits.
- When not defined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Frame 0: pulse spring and frame sources. At startOfFrame, evReady=1 → evCode=2 then evCode=7, each evValid for 1 cycle, busy falls after the second handshake, overrun=0.
- Bumper pulsed 3 times in one frame → exactly one event with evCode=3 next frame.
- Obstacle-good pulses coincident with startOfFrame, and the batch is empty → no dispatch this frame. evCode=5 is dispatched after the following startOfFrame.
- evReady held 0, TIMEOUT_CYCLES=4, batch = sources 4 and 6 → timeoutDrop pulses after 4 PRESENT cycles. evCode=6 is then presented and its timeoutDrop follows.
- Batch = sources 1, 3, 7 with evReady=1 → only evCode=1 is dispatched, then IDLE, no overrun.
- evReady=0 with a batch pending when the next startOfFrame arrives → overrun=1 for one cycle and the new batch is loaded. With COLLISION_EVENT_STATS_EN defined, dropCount increases by the discarded popcount.
